// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_ser_state_t;

    // A single-nibble adder still needs a one-bit index register.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/cla_4bit.sv
// Combinational 4-bit carry-lookahead adder; every carry is flattened from G/P terms.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-nibble adder that reuses one 4-bit CLA, least significant nibble first,
// with the inter-nibble carry held in a flop.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding nibble idx, one per clock
// DONE  | result presented, waiting for out_ready
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        cout,
    output logic                        ovf,
    output logic                        busy
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    cla_ser_state_t state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     sum_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_s;
    logic                nib_cout;

    assign nib_a = a_reg[NIBBLE_W*idx +: NIBBLE_W];
    assign nib_b = b_reg[NIBBLE_W*idx +: NIBBLE_W];

    cla_4bit u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_reg),
        .s    (nib_s),
        .cout (nib_cout)
    );

    // in_ready is registered so it stays low through reset and has no path from rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_reg <= 1'b1;
                    if (in_valid && in_ready_reg) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        carry_reg    <= cin;
                        idx          <= '0;
                        sum_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[NIBBLE_W*idx +: NIBBLE_W] <= nib_s;
                    carry_reg <= nib_cout;
                    if (idx == IDX_LAST) begin
                        cout_reg      <= nib_cout;
                        ovf_reg       <= (a_reg[W-1] == b_reg[W-1]) && (nib_s[NIBBLE_W-1] != a_reg[W-1]);
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;
    assign busy      = (state != IDLE);

endmodule
